// File: rtl/dds_fifo_pkg.sv
// Shared defaults and types for the DDS strobe FIFO.
// The top's optional first-word-fall-through read port is enabled by the DDS_FIFO_FWFT_EN macro.
package dds_fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 256;
    localparam int AFULL_MARGIN = 4;
    localparam int SYNC_STAGES  = 3;

    typedef struct packed {
        logic wr_ok;
        logic rd_ok;
    } commit_t;

endpackage

// File: rtl/dds_strobe_sync.sv
// Three-flop synchroniser for an asynchronous MCU strobe.
// Emits a one-cycle request on the synchronised rising edge.
module dds_strobe_sync
    import dds_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    output logic req
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], stb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Edge is taken between the two settled stages, never from the metastable first flop.
    assign req = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dds_strobe_fifo.sv
// Single-clock FIFO for DDS tuning words, fed by asynchronous MCU write/read strobes.
// Define DDS_FIFO_FWFT_EN for a first-word-fall-through rd_data port.
module dds_strobe_fifo
    import dds_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AFULL_TH = DEPTH - AFULL_MARGIN,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_stb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_stb,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_done,
    output logic              rd_done,
    output logic              full,
    output logic              empty,
    output logic              afull,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_TH);

    // Handshake: one rising strobe edge is one request; the matching *_done pulse
    // (one cycle) means it committed, and no pulse means it was rejected as an error.
    logic    wr_req, rd_req;
    commit_t c;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, full_d, empty_q, empty_d, afull_q, afull_d;
    logic              wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;

    dds_strobe_sync u_wr_sync (.clk(clk), .rst_n(rst_n), .stb(wr_stb), .req(wr_req));
    dds_strobe_sync u_rd_sync (.clk(clk), .rst_n(rst_n), .stb(rd_stb), .req(rd_req));

    always_comb begin
        // A write into a full FIFO is allowed when a read frees the oldest slot on the same edge.
        c.wr_ok     = wr_req & (~full_q | rd_req);
        c.rd_ok     = rd_req & ~empty_q;
        wp_d        = c.wr_ok ? wp_q + 1'b1 : wp_q;
        rp_d        = c.rd_ok ? rp_q + 1'b1 : rp_q;
        level_d     = level_q;
        if (c.wr_ok && !c.rd_ok) level_d = level_q + 1'b1;
        if (c.rd_ok && !c.wr_ok) level_d = level_q - 1'b1;
        full_d      = (level_d == FULL_LVL);
        empty_d     = (level_d == '0);
        afull_d     = (level_d >= AFULL_LVL);
        wr_done_d   = c.wr_ok;
        rd_done_d   = c.rd_ok;
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;
        if (wr_req && full_q && !rd_req) overflow_d  = 1'b1;
        if (rd_req && empty_q)           underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (c.wr_ok) mem_q[wp_q] <= wr_data;
    end

`ifdef DDS_FIFO_FWFT_EN
    assign rd_data = empty_q ? '0 : mem_q[rp_q];
`else
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = c.rd_ok ? mem_q[rp_q] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign afull     = afull_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_dds_strobe_fifo.sv
// Directed self-checking bench for dds_strobe_fifo (registered read port build).
module tb_dds_strobe_fifo;

    localparam int DW       = 8;
    localparam int DEPTH    = 256;
    localparam int AFULL_TH = 252;
    localparam int AW       = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_stb, rd_stb, clr_err;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          wr_done, rd_done, full, empty, afull, overflow, underflow;
    logic [AW:0]   level;

    int            n_chk = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    int            lvl_m;
    bit            ovf_m, unf_m;
    logic [DW-1:0] last_rd;
    int            wr_seen = 0;
    int            rd_seen = 0;

    dds_strobe_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .wr_data(wr_data), .rd_stb(rd_stb),
        .rd_data(rd_data), .wr_done(wr_done), .rd_done(rd_done), .full(full), .empty(empty),
        .afull(afull), .level(level), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    // clock / reset
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (wr_done === 1'b1) wr_seen++;
        if (rd_done === 1'b1) rd_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(lvl_m));
        chk({tag, ".full"}, 32'(full), 32'(lvl_m == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(lvl_m == 0));
        chk({tag, ".afull"}, 32'(afull), 32'(lvl_m >= AFULL_TH));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
        chk({tag, ".unf"}, 32'(underflow), 32'(unf_m));
    endtask

    task automatic model_reset();
        exp_q.delete();
        lvl_m   = 0;
        ovf_m   = 1'b0;
        unf_m   = 1'b0;
        last_rd = '0;
    endtask

    // driver: strobes high 3 clk, low 3 clk; commit lands on the 3rd sampling edge
    task automatic strobe_op(input bit w, input bit r, input logic [DW-1:0] d, input string tag);
        bit            full_m, empty_m, wr_ok, rd_ok;
        logic [DW-1:0] exp_rd;
        full_m  = (lvl_m == DEPTH);
        empty_m = (lvl_m == 0);
        wr_ok   = w && (!full_m || r);
        rd_ok   = r && !empty_m;
        exp_rd  = last_rd;
        if (rd_ok) exp_rd = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        if (w && full_m && !r) ovf_m = 1'b1;
        if (r && empty_m) unf_m = 1'b1;
        lvl_m   = lvl_m + int'(wr_ok) - int'(rd_ok);
        last_rd = exp_rd;

        @(negedge clk);
        wr_data = d;
        wr_stb  = w;
        rd_stb  = r;
        repeat (2) @(negedge clk);
        chk({tag, ".wr_pre"}, 32'(wr_done), 32'd0);
        chk({tag, ".rd_pre"}, 32'(rd_done), 32'd0);
        @(negedge clk);
        chk({tag, ".wr_done"}, 32'(wr_done), 32'(wr_ok));
        chk({tag, ".rd_done"}, 32'(rd_done), 32'(rd_ok));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
        chk_flags(tag);
        wr_stb = 1'b0;
        rd_stb = 1'b0;
        @(negedge clk);
        chk({tag, ".wr_post"}, 32'(wr_done), 32'd0);
        chk({tag, ".rd_post"}, 32'(rd_done), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clr_pulse(input string tag);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        ovf_m   = 1'b0;
        unf_m   = 1'b0;
        chk_flags(tag);
    endtask

    task automatic short_pulse(input bit w, input bit r);
        @(negedge clk);
        #2;
        wr_stb = w;
        rd_stb = r;
        #5;
        wr_stb = 1'b0;
        rd_stb = 1'b0;
    endtask

    initial begin
        int wr_before, rd_before;
        rst_n   = 1'b0;
        wr_stb  = 1'b0;
        rd_stb  = 1'b0;
        clr_err = 1'b0;
        wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.rd_data", 32'(rd_data), 32'd0);
        chk("rst.wr_done", 32'(wr_done), 32'd0);
        chk("rst.rd_done", 32'(rd_done), 32'd0);
        chk_flags("rst");
        rst_n = 1'b1;

        // single word round trip
        strobe_op(1'b1, 1'b0, 8'hA5, "wr_a5");
        strobe_op(1'b0, 1'b1, 8'h00, "rd_a5");

        // read on empty keeps rd_data, sets underflow
        strobe_op(1'b0, 1'b1, 8'h00, "rd_empty");
        clr_pulse("clr_unf");

        // simultaneous on empty: write wins, read underflows
        strobe_op(1'b1, 1'b1, 8'h11, "sim_empty");
        clr_pulse("clr_sim");

        // simultaneous mid-level: level unchanged
        strobe_op(1'b1, 1'b1, 8'h22, "sim_mid");
        strobe_op(1'b0, 1'b1, 8'h00, "rd_22");

        // fill, overflow, full simultaneous, drain across the wrap
        for (int i = 0; i < DEPTH; i++) strobe_op(1'b1, 1'b0, DW'(i), "fill");
        strobe_op(1'b1, 1'b0, 8'hFF, "wr_over");
        clr_pulse("clr_ovf");
        strobe_op(1'b1, 1'b1, 8'hEE, "sim_full");
        for (int i = 0; i < DEPTH; i++) strobe_op(1'b0, 1'b1, 8'h00, "drain");

        // glitch-width strobes are ignored
        wr_before = wr_seen;
        rd_before = rd_seen;
        wr_data   = 8'h77;
        short_pulse(1'b1, 1'b0);
        short_pulse(1'b0, 1'b1);
        short_pulse(1'b1, 1'b1);
        repeat (6) @(negedge clk);
        chk("short.wr_cnt", 32'(wr_seen), 32'(wr_before));
        chk("short.rd_cnt", 32'(rd_seen), 32'(rd_before));
        chk_flags("short");

        // reset with a request already in the synchroniser
        strobe_op(1'b1, 1'b0, 8'h5A, "wr_5a");
        strobe_op(1'b0, 1'b1, 8'h00, "rd_5a");
        strobe_op(1'b1, 1'b0, 8'h66, "wr_66");
        @(negedge clk);
        wr_data = 8'h99;
        wr_stb  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.rd_data", 32'(rd_data), 32'd0);
        chk("midrst.wr_done", 32'(wr_done), 32'd0);
        chk_flags("midrst");
        wr_stb    = 1'b0;
        wr_before = wr_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst.wr_cnt", 32'(wr_seen), 32'(wr_before));
        chk_flags("midrst_post");
        strobe_op(1'b1, 1'b0, 8'hC3, "wr_c3");
        strobe_op(1'b0, 1'b1, 8'h00, "rd_c3");

        // final report
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
